// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bundle between the keypad/operand front end (master) and the BCD add/sub controller (slave).
// The err signal exists only when BCD_CHECK_EN is defined.
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  // start is a request sampled only while the controller is idle; it is not held off or queued.
  // done pulses for one cycle, and result/cout/neg (and err) are valid in that cycle.
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  cout;
  logic                  neg;
  logic [1:0]            state_dbg;
`ifdef BCD_CHECK_EN
  logic                  err;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, neg, state_dbg, err
  );
  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, neg, state_dbg, err
  );
`else
  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, neg, state_dbg
  );
  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, neg, state_dbg
  );
`endif
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one BCD digit cell reused per cycle, sign+magnitude result.
// Define BCD_CHECK_EN to reject operands holding non-BCD nibbles (adds the err output).
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input logic                clk,
  input logic                rst_n,
  bcd_serial_addsub_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  result_q;
  logic [IW-1:0] idx_q;
  logic          sub_q;
  logic          carry_q;
  logic          busy_q;
  logic          done_q;
  logic          cout_q;
  logic          neg_q;
`ifdef BCD_CHECK_EN
  logic          err_q;
`endif

  // Single-digit BCD adder cell (BCDadd) and its operand steering.
  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [3:0] r_dig;
  logic [3:0] cell_x;
  logic [3:0] cell_y;
  logic [4:0] cell_raw;
  logic [3:0] cell_sum;
  logic       cell_co;
  logic       last_dig;

  always_comb begin
    a_dig  = a_q[int'(idx_q) * 4 +: 4];
    b_dig  = b_q[int'(idx_q) * 4 +: 4];
    r_dig  = result_q[int'(idx_q) * 4 +: 4];
    cell_x = a_dig;
    cell_y = b_dig;
    if (state_q == FIX) begin
      // Second pass forms the tens complement of the first-pass result.
      cell_x = 4'd0;
      cell_y = 4'd9 - r_dig;
    end else if (sub_q) begin
      cell_y = 4'd9 - b_dig;
    end
    cell_raw = {1'b0, cell_x} + {1'b0, cell_y} + {4'd0, carry_q};
    cell_co  = (cell_raw > 5'd9);
    cell_sum = cell_co ? (cell_raw[3:0] + 4'd6) : cell_raw[3:0];
    last_dig = (idx_q == LAST_IDX);
  end

`ifdef BCD_CHECK_EN
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      neg_q    <= 1'b0;
`ifdef BCD_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.sub;
            idx_q   <= '0;
            carry_q <= bus.sub;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
`ifdef BCD_CHECK_EN
            if (has_bad_digit(bus.a) || has_bad_digit(bus.b)) begin
              result_q <= '0;
              err_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
`else
            busy_q  <= 1'b1;
            state_q <= RUN;
`endif
          end
        end

        RUN: begin
          result_q[int'(idx_q) * 4 +: 4] <= cell_sum;
          carry_q <= cell_co;
          if (last_dig) begin
            idx_q <= '0;
            if (sub_q && !cell_co) begin
              // No end-around carry: a < b, so recomplement to get b - a.
              carry_q <= 1'b1;
              state_q <= FIX;
            end else begin
              cout_q  <= sub_q ? 1'b0 : cell_co;
              neg_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        FIX: begin
          result_q[int'(idx_q) * 4 +: 4] <= cell_sum;
          carry_q <= cell_co;
          if (last_dig) begin
            idx_q   <= '0;
            neg_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.neg       = neg_q;
  assign bus.state_dbg = state_q;
`ifdef BCD_CHECK_EN
  assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub: directed BCD vectors, latency/busy accounting, abort and start-hold cases.
`timescale 1ns/1ps
module tb_bcd_serial_addsub;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int EW     = W + 19;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();
  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // Expected word: {busy cycles[7:0], latency[7:0], err, neg, cout, result}
  logic [EW-1:0] exp_q[$];
  int            start_q[$];
  int            n_tests  = 0;
  int            n_fail   = 0;
  int            done_cnt = 0;
  int            busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    int            t0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: done with no op pending, result %0h", bus.result);
          end else begin
            e  = exp_q.pop_front();
            t0 = start_q.pop_front();
            check("result",       32'(bus.result), 32'(e[W-1:0]));
            check("cout",         32'(bus.cout),   32'(e[W]));
            check("neg",          32'(bus.neg),    32'(e[W+1]));
`ifdef BCD_CHECK_EN
            check("err",          32'(bus.err),    32'(e[W+2]));
`endif
            check("latency",      32'(cyc - t0),   32'(e[W+10:W+3]));
            check("busy_cycles",  32'(busy_cnt),   32'(e[W+18:W+11]));
            check("busy_at_done", 32'(bus.busy),   32'd0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] er, input logic ec, input logic en, input logic ee,
                        input int elat, input int ebusy, input int hold);
    int target;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = av;
    bus.b     = bv;
    exp_q.push_back({8'(ebusy), 8'(elat), ee, en, ec, er});
    start_q.push_back(cyc);
    target = done_cnt + 1;
    // Extra start cycles carry different operands; the DUT must ignore them.
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      bus.a   = ~av;
      bus.b   = av;
      bus.sub = ~s;
    end
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 40 && done_cnt < target; i++) @(negedge clk);
    if (done_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no done within 40 cycles for a=%0h b=%0h sub=%0b", av, bv, s);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, 32'(bus.result),    32'd0);
    check({tag, "_busy"},   32'(bus.busy),      32'd0);
    check({tag, "_done"},   32'(bus.done),      32'd0);
    check({tag, "_cout"},   32'(bus.cout),      32'd0);
    check({tag, "_neg"},    32'(bus.neg),       32'd0);
    check({tag, "_state"},  32'(bus.state_dbg), 32'd0);
`ifdef BCD_CHECK_EN
    check({tag, "_err"},    32'(bus.err),       32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int saved;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    //     sub   a         b         result    cout  neg   err   lat bsy hold
    run_op(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 5, 4, 1);
    run_op(1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 5, 4, 1);
    run_op(1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 1'b0, 5, 4, 1);
    run_op(1'b1, 16'h0420, 16'h0420, 16'h0000, 1'b0, 1'b0, 1'b0, 5, 4, 1);
    run_op(1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b0, 1'b1, 1'b0, 9, 8, 1);
    run_op(1'b0, 16'h4567, 16'h5433, 16'h0000, 1'b1, 1'b0, 1'b0, 5, 4, 1);
    run_op(1'b0, 16'h0505, 16'h0505, 16'h1010, 1'b0, 1'b0, 1'b0, 5, 4, 1);
    run_op(1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 9, 8, 1);
    run_op(1'b1, 16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 1'b0, 5, 4, 1);
    run_op(1'b1, 16'h0000, 16'h9999, 16'h9999, 1'b0, 1'b1, 1'b0, 9, 8, 1);

    // start held high through RUN with changing operands: only the first op counts
    run_op(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 5, 4, 4);
    repeat (12) @(negedge clk);

    // abort a negative subtraction at RUN digit 2
    saved = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h5000;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_run", 32'(bus.state_dbg), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt), 32'(saved));
    run_op(1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b0, 1'b1, 1'b0, 9, 8, 1);

`ifdef BCD_CHECK_EN
    run_op(1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 0, 1);
    run_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 5, 4, 1);
    run_op(1'b1, 16'h0001, 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 0, 1);
    run_op(1'b1, 16'h0001, 16'h0002, 16'h0001, 1'b0, 1'b1, 1'b0, 9, 8, 1);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    summary();
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    summary();
    $fatal(1, "watchdog expired");
  end

endmodule
